usb_link_power_ctrl: RTL and testbench

Device-side USB link power-state controller. It consumes the bus-event flags from the line-state monitor (reset/suspend/resume detect) and sequences the link through its active, bus-reset, suspend, remote-wakeup and resume phases. It drives the UTMI SuspendM control and the remote-wakeup K request toward the PHY/TX path, and raises single-cycle event pulses for the device core.

---
 rtl/usb_link_power_ctrl_if.sv | 31 +++
 rtl/usb_link_power_ctrl.sv | 125 ++++++++++++
 tb/tb_usb_link_power_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_link_power_ctrl_if.sv
// Signal bundle between the line-state monitor / device core and the USB link power controller.
// The slave side is the controller; the master side drives the bus-event flags and consumes the outputs.
interface usb_link_power_ctrl_if;
   logic [1:0] line_state;
   logic       reset_detect;
   logic       suspend_detect;
   logic       resume_detect;
   logic       remote_wake_req;
   logic       remote_wake_en;
   logic [2:0] link_state;
   logic       phy_suspend_n;
   logic       drive_k;
   logic       bus_reset_pulse;
   logic       suspend_irq;
   logic       resume_irq;
   logic       wake_busy;

   modport slave (
      input  line_state, reset_detect, suspend_detect, resume_detect,
             remote_wake_req, remote_wake_en,
      output link_state, phy_suspend_n, drive_k, bus_reset_pulse,
             suspend_irq, resume_irq, wake_busy
   );

   modport master (
      output line_state, reset_detect, suspend_detect, resume_detect,
             remote_wake_req, remote_wake_en,
      input  link_state, phy_suspend_n, drive_k, bus_reset_pulse,
             suspend_irq, resume_irq, wake_busy
   );
endinterface

// File: rtl/usb_link_power_ctrl.sv
// Device-side USB link power-state controller: sequences active, bus reset, suspend,
// remote wakeup and resume, driving SuspendM, the wake K request and core event pulses.
module usb_link_power_ctrl #(
   parameter int CLK_FREQ_MHZ = 60,
   parameter int WAKE_IDLE_US = 5000,
   parameter int WAKE_K_US    = 2000
) (
   input logic                  clk,
   input logic                  rst_n,
   usb_link_power_ctrl_if.slave bus
);

   localparam logic [23:0] WAKE_IDLE_CYC = 24'(CLK_FREQ_MHZ * WAKE_IDLE_US);
   localparam logic [23:0] WAKE_K_CYC    = 24'(CLK_FREQ_MHZ * WAKE_K_US);
   localparam logic [23:0] WAKE_K_LAST   = WAKE_K_CYC - 24'd1;

   typedef enum logic [2:0] {
      ACTIVE     = 3'd0,
      BUS_RESET  = 3'd1,
      SUSPEND    = 3'd2,
      WAKE_WAIT  = 3'd3,
      WAKE_DRIVE = 3'd4,
      RESUME     = 3'd5
   } link_state_e;

   link_state_e state;
   link_state_e state_nxt;
   logic [23:0] cnt;
   logic [23:0] cnt_nxt;
   logic        susp_q;
   logic        susp_rise;
   logic        wake_req;
   logic        phy_suspend_n_q;
   logic        drive_k_q;
   logic        bus_reset_pulse_q;
   logic        suspend_irq_q;
   logic        resume_irq_q;
   logic        wake_busy_q;

   assign susp_rise = bus.suspend_detect & ~susp_q;
   assign wake_req  = bus.remote_wake_req & bus.remote_wake_en;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (bus.reset_detect) begin
         state_nxt = BUS_RESET;
      end else begin
         case (state)
            ACTIVE: begin
               if (susp_rise) state_nxt = SUSPEND;
            end
            BUS_RESET: begin
               state_nxt = ACTIVE;
            end
            SUSPEND: begin
               if (bus.resume_detect) begin
                  state_nxt = RESUME;
               end else if (wake_req) begin
                  state_nxt = (cnt >= WAKE_IDLE_CYC) ? WAKE_DRIVE : WAKE_WAIT;
               end else if (cnt < WAKE_IDLE_CYC) begin
                  cnt_nxt = cnt + 24'd1;
               end
            end
            WAKE_WAIT: begin
               if (bus.resume_detect) begin
                  state_nxt = RESUME;
               end else if (cnt >= WAKE_IDLE_CYC) begin
                  state_nxt = WAKE_DRIVE;
               end else begin
                  cnt_nxt = cnt + 24'd1;
               end
            end
            // The host-resume flag here is our own K echoed back, so it is not looked at.
            WAKE_DRIVE: begin
               if (cnt == WAKE_K_LAST) state_nxt = RESUME;
               else                    cnt_nxt   = cnt + 24'd1;
            end
            RESUME: begin
               if (bus.line_state != 2'b10) state_nxt = ACTIVE;
            end
            default: begin
               state_nxt = ACTIVE;
            end
         endcase
      end
      // The idle time already spent in SUSPEND carries into WAKE_WAIT.
      if ((state_nxt != state) && !((state == SUSPEND) && (state_nxt == WAKE_WAIT))) begin
         cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= ACTIVE;
         cnt               <= '0;
         susp_q            <= 1'b0;
         phy_suspend_n_q   <= 1'b1;
         drive_k_q         <= 1'b0;
         bus_reset_pulse_q <= 1'b0;
         suspend_irq_q     <= 1'b0;
         resume_irq_q      <= 1'b0;
         wake_busy_q       <= 1'b0;
      end else begin
         state             <= state_nxt;
         cnt               <= cnt_nxt;
         susp_q            <= bus.suspend_detect;
         phy_suspend_n_q   <= !((state_nxt == SUSPEND) || (state_nxt == WAKE_WAIT));
         drive_k_q         <= (state_nxt == WAKE_DRIVE);
         wake_busy_q       <= (state_nxt == WAKE_WAIT) || (state_nxt == WAKE_DRIVE);
         bus_reset_pulse_q <= (state_nxt == BUS_RESET) && (state != BUS_RESET);
         suspend_irq_q     <= (state_nxt == SUSPEND) && (state != SUSPEND);
         resume_irq_q      <= (state_nxt == RESUME) && (state != RESUME);
      end
   end

   assign bus.link_state      = state;
   assign bus.phy_suspend_n   = phy_suspend_n_q;
   assign bus.drive_k         = drive_k_q;
   assign bus.wake_busy       = wake_busy_q;
   assign bus.bus_reset_pulse = bus_reset_pulse_q;
   assign bus.suspend_irq     = suspend_irq_q;
   assign bus.resume_irq      = resume_irq_q;

endmodule

// File: tb/tb_usb_link_power_ctrl.sv
// Testbench for usb_link_power_ctrl: directed link-power scenarios plus random bus events,
// checked every cycle against a timestamp-based reference model.
module tb_usb_link_power_ctrl;

   localparam int P_CLK     = 1;
   localparam int P_IDLE_US = 50;
   localparam int P_K_US    = 20;
   localparam int IDLE      = P_CLK * P_IDLE_US;
   localparam int K         = P_CLK * P_K_US;

   localparam int S_ACTIVE     = 0;
   localparam int S_BUS_RESET  = 1;
   localparam int S_SUSPEND    = 2;
   localparam int S_WAKE_WAIT  = 3;
   localparam int S_WAKE_DRIVE = 4;
   localparam int S_RESUME     = 5;

   logic clk = 1'b0;
   logic rst_n;

   usb_link_power_ctrl_if bus();

   usb_link_power_ctrl #(
      .CLK_FREQ_MHZ (P_CLK),
      .WAKE_IDLE_US (P_IDLE_US),
      .WAKE_K_US    (P_K_US)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 0;
   int n_bus = 0;
   int n_susp = 0;
   int n_res = 0;
   int n_dk = 0;
   int n_st1 = 0;

   // Reference model: tracks the link phase with absolute edge timestamps.
   int cyc = 0;
   int m_state = S_ACTIVE;
   bit m_bus = 0;
   bit m_susp = 0;
   bit m_res = 0;
   bit m_sprev = 0;
   bit m_rise;
   int t_susp = 0;
   int t_drive = 0;
   int m_c;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = S_ACTIVE;
         m_bus   = 0;
         m_susp  = 0;
         m_res   = 0;
         m_sprev = 0;
      end else begin
         cyc++;
         m_rise  = bus.suspend_detect && !m_sprev;
         m_sprev = bus.suspend_detect;
         m_bus   = 0;
         m_susp  = 0;
         m_res   = 0;
         if (bus.reset_detect) begin
            if (m_state != S_BUS_RESET) m_bus = 1;
            m_state = S_BUS_RESET;
         end else begin
            case (m_state)
               S_ACTIVE: if (m_rise) begin
                  m_state = S_SUSPEND;
                  m_susp  = 1;
                  t_susp  = cyc;
               end
               S_BUS_RESET: m_state = S_ACTIVE;
               S_SUSPEND: begin
                  if (bus.resume_detect) begin
                     m_state = S_RESUME;
                     m_res   = 1;
                  end else if (bus.remote_wake_req && bus.remote_wake_en) begin
                     // Idle time seen by this edge; a short one is made up in WAKE_WAIT.
                     m_c = cyc - t_susp - 1;
                     if (m_c >= IDLE) begin
                        m_state = S_WAKE_DRIVE;
                        t_drive = cyc;
                     end else begin
                        m_state = S_WAKE_WAIT;
                        t_drive = t_susp + IDLE + 2;
                     end
                  end
               end
               S_WAKE_WAIT: begin
                  if (bus.resume_detect) begin
                     m_state = S_RESUME;
                     m_res   = 1;
                  end else if (cyc == t_drive) begin
                     m_state = S_WAKE_DRIVE;
                  end
               end
               S_WAKE_DRIVE: if (cyc == t_drive + K) begin
                  m_state = S_RESUME;
                  m_res   = 1;
               end
               S_RESUME: if (bus.line_state != 2'b10) m_state = S_ACTIVE;
               default: m_state = S_ACTIVE;
            endcase
         end
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic applyStimulus(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " link_state"}, int'(bus.link_state), 0);
      checkOutput({tag, " phy_suspend_n"}, int'(bus.phy_suspend_n), 1);
      checkOutput({tag, " drive_k"}, int'(bus.drive_k), 0);
      checkOutput({tag, " bus_reset_pulse"}, int'(bus.bus_reset_pulse), 0);
      checkOutput({tag, " suspend_irq"}, int'(bus.suspend_irq), 0);
      checkOutput({tag, " resume_irq"}, int'(bus.resume_irq), 0);
      checkOutput({tag, " wake_busy"}, int'(bus.wake_busy), 0);
   endtask

   task automatic compareLoop();
      forever begin
         @(negedge clk);
         if (chk_en) begin
            checkOutput("link_state", int'(bus.link_state), m_state);
            checkOutput("phy_suspend_n", int'(bus.phy_suspend_n),
                        (m_state == S_SUSPEND || m_state == S_WAKE_WAIT) ? 0 : 1);
            checkOutput("drive_k", int'(bus.drive_k), (m_state == S_WAKE_DRIVE) ? 1 : 0);
            checkOutput("wake_busy", int'(bus.wake_busy),
                        (m_state == S_WAKE_WAIT || m_state == S_WAKE_DRIVE) ? 1 : 0);
            checkOutput("bus_reset_pulse", int'(bus.bus_reset_pulse), int'(m_bus));
            checkOutput("suspend_irq", int'(bus.suspend_irq), int'(m_susp));
            checkOutput("resume_irq", int'(bus.resume_irq), int'(m_res));
         end
         if (bus.bus_reset_pulse) n_bus++;
         if (bus.suspend_irq) n_susp++;
         if (bus.resume_irq) n_res++;
         if (bus.drive_k) n_dk++;
         if (bus.link_state == 3'd1) n_st1++;
      end
   endtask

   // Suspend for the given number of edges, then issue a one-cycle wake request.
   task automatic suspendAndWake(input int idle_edges);
      bus.suspend_detect = 1'b1;
      applyStimulus(1 + idle_edges);
      bus.remote_wake_req = 1'b1;
      applyStimulus(1);
      bus.remote_wake_req = 1'b0;
   endtask

   task automatic runTests();
      int b0;
      int s0;
      int w;
      int rd_run;

      rst_n = 1'b1;
      bus.line_state      = 2'b01;
      bus.reset_detect    = 1'b0;
      bus.suspend_detect  = 1'b0;
      bus.resume_detect   = 1'b0;
      bus.remote_wake_req = 1'b0;
      bus.remote_wake_en  = 1'b0;
      #1 rst_n = 1'b0;
      applyStimulus(3);
      checkResetValues("reset");
      rst_n = 1'b1;
      applyStimulus(2);
      chk_en = 1;

      // Bus reset held for 10 cycles
      b0 = n_bus;
      s0 = n_st1;
      bus.reset_detect = 1'b1;
      applyStimulus(10);
      bus.reset_detect = 1'b0;
      applyStimulus(3);
      checkOutput("busreset pulse count", n_bus - b0, 1);
      checkOutput("busreset state1 cycles", n_st1 - s0, 10);
      checkOutput("busreset back to active", int'(bus.link_state), 0);

      // Suspend then host resume
      s0 = n_susp;
      bus.suspend_detect = 1'b1;
      applyStimulus(2);
      checkOutput("suspend irq count", n_susp - s0, 1);
      checkOutput("suspend phy_suspend_n", int'(bus.phy_suspend_n), 0);
      s0 = n_res;
      bus.resume_detect = 1'b1;
      bus.line_state = 2'b10;
      applyStimulus(1);
      bus.resume_detect = 1'b0;
      applyStimulus(4);
      checkOutput("resume held in K", int'(bus.link_state), 5);
      checkOutput("resume phy_suspend_n", int'(bus.phy_suspend_n), 1);
      bus.line_state = 2'b01;
      applyStimulus(1);
      checkOutput("resume exit after K", int'(bus.link_state), 0);
      checkOutput("resume irq count", n_res - s0, 1);
      bus.suspend_detect = 1'b0;
      applyStimulus(2);

      // Early remote wake at cnt = 10
      bus.remote_wake_en = 1'b1;
      suspendAndWake(10);
      checkOutput("early wake state", int'(bus.link_state), 3);
      checkOutput("early wake busy", int'(bus.wake_busy), 1);
      w = 0;
      while (!bus.drive_k && w < 100) begin applyStimulus(1); w++; end
      checkOutput("early wake K delay", w, 41);
      w = 0;
      while (bus.drive_k && w < 100) begin applyStimulus(1); w++; end
      checkOutput("early wake K width", w, 20);
      checkOutput("early wake resume", int'(bus.link_state), 5);
      applyStimulus(2);
      bus.suspend_detect = 1'b0;
      applyStimulus(1);

      // Late remote wake: straight to WAKE_DRIVE
      suspendAndWake(60);
      checkOutput("late wake state", int'(bus.link_state), 4);
      checkOutput("late wake drive_k", int'(bus.drive_k), 1);
      applyStimulus(25);
      bus.suspend_detect = 1'b0;
      applyStimulus(1);

      // Wake request with remote wakeup disabled is dropped
      bus.remote_wake_en = 1'b0;
      s0 = n_dk;
      suspendAndWake(60);
      applyStimulus(5);
      checkOutput("disabled wake state", int'(bus.link_state), 2);
      checkOutput("disabled wake drive_k cycles", n_dk - s0, 0);
      bus.resume_detect = 1'b1;
      applyStimulus(1);
      bus.resume_detect = 1'b0;
      applyStimulus(2);
      bus.suspend_detect = 1'b0;
      bus.remote_wake_en = 1'b1;
      applyStimulus(1);

      // Host resume colliding with a wake request
      bus.suspend_detect = 1'b1;
      applyStimulus(3);
      bus.resume_detect = 1'b1;
      bus.remote_wake_req = 1'b1;
      applyStimulus(1);
      bus.resume_detect = 1'b0;
      bus.remote_wake_req = 1'b0;
      checkOutput("collision state", int'(bus.link_state), 5);
      checkOutput("collision wake_busy", int'(bus.wake_busy), 0);
      applyStimulus(1);
      bus.suspend_detect = 1'b0;
      applyStimulus(1);

      // Resume flag during WAKE_DRIVE is ignored
      suspendAndWake(60);
      bus.resume_detect = 1'b1;
      w = 0;
      while (bus.drive_k && w < 100) begin applyStimulus(1); w++; end
      bus.resume_detect = 1'b0;
      checkOutput("resume-in-drive K width", w, 20);
      applyStimulus(2);
      bus.suspend_detect = 1'b0;
      applyStimulus(1);

      // Bus reset at cycle 5 of WAKE_DRIVE
      suspendAndWake(60);
      applyStimulus(4);
      b0 = n_bus;
      bus.reset_detect = 1'b1;
      applyStimulus(1);
      checkOutput("reset mid-drive state", int'(bus.link_state), 1);
      checkOutput("reset mid-drive drive_k", int'(bus.drive_k), 0);
      checkOutput("reset mid-drive pulse", n_bus - b0, 1);
      bus.reset_detect = 1'b0;
      applyStimulus(2);
      bus.suspend_detect = 1'b0;
      applyStimulus(1);

      // Asynchronous reset mid WAKE_DRIVE
      suspendAndWake(60);
      applyStimulus(3);
      checkOutput("pre-async drive_k", int'(bus.drive_k), 1);
      bus.suspend_detect = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkResetValues("async reset");
      applyStimulus(2);
      rst_n = 1'b1;
      applyStimulus(2);

      // Random bus events against the model
      rd_run = 0;
      for (int i = 0; i < 3000; i++) begin
         if (rd_run == 0 && $urandom_range(0, 299) == 0) rd_run = $urandom_range(1, 6);
         bus.reset_detect = (rd_run > 0);
         if (rd_run > 0) rd_run--;
         if ($urandom_range(0, 39) == 0) bus.suspend_detect = ~bus.suspend_detect;
         bus.resume_detect   = ($urandom_range(0, 99) == 0);
         bus.remote_wake_req = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 59) == 0) bus.remote_wake_en = ~bus.remote_wake_en;
         bus.line_state = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom_range(0, 3));
         applyStimulus(1);
      end
      bus.reset_detect = 1'b0;
      applyStimulus(2);
   endtask

   initial begin
      fork
         compareLoop();
         runTests();
      join_any
      disable fork;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
